// File: rtl/mips_memory.sv
// Unified word-addressed memory behind the MIPS core: async fetch port, sync data port,
// and a power-up sequencer (clear, then program load) that holds the core in reset.
module mips_memory #(
    parameter logic [31:0] base_addr      = 32'h0000_0000,
    parameter int          depth_words    = 1024,
    parameter bit          clear_on_reset = 1'b1
) (
    input  logic        clk,
    input  logic        i_reset,        // active-low, asynchronous
    input  logic [31:0] i_instr_addr,
    output logic [31:0] o_instr_in,
    input  logic [31:0] i_data_addr,
    input  logic        i_data_rd_wr,
    input  logic [31:0] i_data_out,
    output logic [31:0] o_data_in,
    input  logic        i_load_valid,
    output logic        o_load_ready,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data,
    input  logic        i_load_done,
    output logic        o_core_reset,
    output logic        o_addr_error
);

    localparam int          IDX_W  = $clog2(depth_words);
    localparam logic [31:0] DEPTH_L = 32'(depth_words);

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;
    localparam state_t S_INIT = clear_on_reset ? S_CLEAR : S_LOAD;

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - base_addr;
        return (a >= base_addr) && ((off >> 2) < DEPTH_L);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - base_addr;
        return IDX_W'(off >> 2);
    endfunction

    logic [31:0]      r_mem [depth_words];
    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_clr_idx;
    logic [31:0]      r_data_in;
    logic             r_core_reset;
    logic             r_load_ready;
    logic             r_addr_error;

    logic             w_instr_ok;
    logic             w_data_ok;
    logic             w_load_ok;
    logic [IDX_W-1:0] w_instr_idx;
    logic [IDX_W-1:0] w_data_idx;
    logic [IDX_W-1:0] w_load_idx;
    logic             w_clr_last;
    logic             w_load_acc;
    logic             w_err_hit;
    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    logic [31:0]      w_wdata;

    assign w_instr_ok  = addr_ok(i_instr_addr);
    assign w_data_ok   = addr_ok(i_data_addr);
    assign w_load_ok   = addr_ok(i_load_addr);
    assign w_instr_idx = addr_idx(i_instr_addr);
    assign w_data_idx  = addr_idx(i_data_addr);
    assign w_load_idx  = addr_idx(i_load_addr);
    assign w_clr_last  = (r_clr_idx == IDX_W'(depth_words - 1));
    assign w_load_acc  = (r_state == S_LOAD) && i_load_valid && r_load_ready;

    // Fetch addresses only matter once the core is out of reset.
    assign w_err_hit = ((r_state == S_RUN) && (!w_instr_ok || !w_data_ok))
                     || (w_load_acc && !w_load_ok);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (w_clr_last) w_state_next = S_LOAD;
            S_LOAD:  if (i_load_done) w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    // Exactly one writer owns the array in each state.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = '0;
        w_wdata = '0;
        case (r_state)
            S_CLEAR: begin
                w_we   = 1'b1;
                w_widx = r_clr_idx;
            end
            S_LOAD: begin
                w_we    = w_load_acc && w_load_ok;
                w_widx  = w_load_idx;
                w_wdata = i_load_data;
            end
            default: begin
                w_we    = !i_data_rd_wr && w_data_ok;
                w_widx  = w_data_idx;
                w_wdata = i_data_out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_wdata;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_INIT;
            r_clr_idx    <= '0;
            r_data_in    <= '0;
            r_core_reset <= 1'b1;
            r_load_ready <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_core_reset <= (w_state_next != S_RUN);
            r_load_ready <= (w_state_next == S_LOAD);
            if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDX_W'(1);
            if ((r_state == S_RUN) && i_data_rd_wr)
                r_data_in <= w_data_ok ? r_mem[w_data_idx] : 32'h0;
            if (w_err_hit) r_addr_error <= 1'b1;
        end
    end

    assign o_instr_in   = ((r_state != S_CLEAR) && w_instr_ok) ? r_mem[w_instr_idx] : 32'h0;
    assign o_data_in    = r_data_in;
    assign o_core_reset = r_core_reset;
    assign o_load_ready = r_load_ready;
    assign o_addr_error = r_addr_error;

endmodule

// File: tb/tb_mips_memory.sv
// Self-checking bench for mips_memory: array-based reference model, random RUN traffic,
// power-up sequencing, out-of-range handling and reset aborts.
module tb_mips_memory;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_instr_addr, o_instr_in, i_data_addr, i_data_out, o_data_in;
    logic        i_data_rd_wr, i_load_valid, o_load_ready, i_load_done;
    logic [31:0] i_load_addr, i_load_data;
    logic        o_core_reset, o_addr_error;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_din;
    logic        exp_err;

    mips_memory #(.base_addr(BASE), .depth_words(DEPTH), .clear_on_reset(1'b1)) dut (
        .clk(clk), .i_reset(rst_n),
        .i_instr_addr(i_instr_addr), .o_instr_in(o_instr_in),
        .i_data_addr(i_data_addr), .i_data_rd_wr(i_data_rd_wr),
        .i_data_out(i_data_out), .o_data_in(o_data_in),
        .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .i_load_done(i_load_done), .o_core_reset(o_core_reset),
        .o_addr_error(o_addr_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] waddr(input int idx);
        return BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
    endfunction

    task automatic idle();
        i_load_valid = 1'b0; i_load_done = 1'b0; i_load_addr = BASE; i_load_data = '0;
        i_data_rd_wr = 1'b1; i_data_addr = BASE; i_data_out = '0; i_instr_addr = BASE;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_din = '0;
        exp_err = 1'b0;
    endtask

    // One core data-port cycle in RUN; the model follows the memory rules directly.
    task automatic run_op(input logic rd, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off;
        logic        ok;
        off = addr - BASE;
        ok  = (addr >= BASE) && (off / 4 < DEPTH);
        i_data_rd_wr = rd; i_data_addr = addr; i_data_out = wd;
        tick();
        if (ok) begin
            if (rd) exp_din = model[off / 4];
            else    model[off / 4] = wd;
        end else begin
            if (rd) exp_din = '0;
            exp_err = 1'b1;
        end
        $display("op rd=%0b addr=%h wdata=%h data_in=%h err=%0b", rd, addr, wd, o_data_in, o_addr_error);
    endtask

    task automatic power_up();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (DEPTH) tick();
        clear_model();
    endtask

    task automatic test_load();
        int idx;
        logic [31:0] d;
        total++; if (o_load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_entry got=%b exp=1", o_load_ready); end
        for (int k = 0; k < 6; k++) begin
            idx = (k == 0) ? 5 : int'($urandom_range(2, DEPTH - 1));
            d = $urandom | 32'h1;
            i_load_valid = 1'b1; i_load_addr = waddr(idx); i_load_data = d;
            tick();
            model[idx] = d;
            $display("load addr=%h data=%h", i_load_addr, d);
            total++; if (o_core_reset !== 1'b1) begin bad++; $display("FAIL load_core_reset got=%b exp=1", o_core_reset); end
        end
        i_load_valid = 1'b0;
        tick();
        total++; if (o_load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_idle got=%b exp=1", o_load_ready); end
        i_load_valid = 1'b1; i_load_addr = BASE; i_load_data = 32'h2402_0005;
        tick(); model[0] = 32'h2402_0005;
        i_load_addr = BASE + 32'd4; i_load_data = 32'h8FA4_0000; i_load_done = 1'b1;
        tick(); model[1] = 32'h8FA4_0000;
        i_load_valid = 1'b0; i_load_done = 1'b0;
        $display("load done");
        total++; if (o_core_reset !== 1'b0) begin bad++; $display("FAIL done_core_reset got=%b exp=0", o_core_reset); end
        total++; if (o_load_ready !== 1'b0) begin bad++; $display("FAIL done_load_ready got=%b exp=0", o_load_ready); end
        i_instr_addr = BASE + 32'd4; #1;
        total++; if (o_instr_in !== 32'h8FA4_0000) begin bad++; $display("FAIL fetch_word1 got=%h exp=8fa40000", o_instr_in); end
        for (int i = 0; i < DEPTH; i++) begin
            i_instr_addr = waddr(i); #1;
            total++; if (o_instr_in !== model[i]) begin bad++; $display("FAIL fetch_loaded[%0d] got=%h exp=%h", i, o_instr_in, model[i]); end
        end
        // Time has advanced through RUN edges with an idle read of word 0.
        i_instr_addr = BASE;
        tick();
        exp_din = model[0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        total++; if (o_core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%b exp=1", o_core_reset); end
        total++; if (o_load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready got=%b exp=0", o_load_ready); end
        total++; if (o_data_in !== 32'h0) begin bad++; $display("FAIL rst_data_in got=%h exp=0", o_data_in); end
        total++; if (o_addr_error !== 1'b0) begin bad++; $display("FAIL rst_addr_error got=%b exp=0", o_addr_error); end
        clear_model();
        idle();
        i_instr_addr = BASE + 32'd20;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= DEPTH; c++) begin
            tick();
            if (c < DEPTH) begin
                total++; if ({o_load_ready, o_core_reset} !== 2'b01) begin bad++; $display("FAIL clear_busy c=%0d got=%b exp=01", c, {o_load_ready, o_core_reset}); end
                total++; if (o_instr_in !== 32'h0) begin bad++; $display("FAIL clear_instr c=%0d got=%h exp=0", c, o_instr_in); end
            end
        end
        $display("clear complete");
        total++; if (o_load_ready !== 1'b1) begin bad++; $display("FAIL clear_end_ready got=%b exp=1", o_load_ready); end
        total++; if (o_core_reset !== 1'b1) begin bad++; $display("FAIL clear_end_core got=%b exp=1", o_core_reset); end
        total++; if (o_instr_in !== 32'h0) begin bad++; $display("FAIL word5_cleared got=%h exp=0", o_instr_in); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        prev = exp_din;
        i_instr_addr = BASE + 32'd8;
        i_data_rd_wr = 1'b0; i_data_addr = BASE + 32'd8; i_data_out = 32'hDEAD_BEEF; #1;
        total++; if (o_instr_in !== model[2]) begin bad++; $display("FAIL fetch_old got=%h exp=%h", o_instr_in, model[2]); end
        run_op(1'b0, BASE + 32'd8, 32'hDEAD_BEEF);
        total++; if (o_data_in !== prev) begin bad++; $display("FAIL write_holds got=%h exp=%h", o_data_in, prev); end
        total++; if (o_instr_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_new got=%h exp=deadbeef", o_instr_in); end
        run_op(1'b1, BASE + 32'd8, '0);
        total++; if (o_data_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_back got=%h exp=deadbeef", o_data_in); end
        run_op(1'b1, BASE + 32'd12, '0);
        total++; if (o_data_in !== exp_din) begin bad++; $display("FAIL read_word3 got=%h exp=%h", o_data_in, exp_din); end
        run_op(1'b1, BASE + 32'd9, '0);
        total++; if (o_data_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_plus9 got=%h exp=deadbeef", o_data_in); end
        run_op(1'b1, BASE + 32'd11, '0);
        total++; if (o_data_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_plus11 got=%h exp=deadbeef", o_data_in); end
        total++; if (o_addr_error !== 1'b0) begin bad++; $display("FAIL misalign_no_err got=%b exp=0", o_addr_error); end
    endtask

    task automatic test_random_rw();
        int idx, iidx;
        for (int n = 0; n < 40; n++) begin
            idx  = int'($urandom_range(0, DEPTH - 1));
            iidx = int'($urandom_range(0, DEPTH - 1));
            i_instr_addr = waddr(iidx);
            run_op(1'($urandom_range(0, 1)), waddr(idx), $urandom);
            total++; if (o_data_in !== exp_din) begin bad++; $display("FAIL rw_data n=%0d got=%h exp=%h", n, o_data_in, exp_din); end
            total++; if (o_instr_in !== model[iidx]) begin bad++; $display("FAIL rw_instr n=%0d got=%h exp=%h", n, o_instr_in, model[iidx]); end
            total++; if (o_addr_error !== 1'b0) begin bad++; $display("FAIL rw_err n=%0d got=%b exp=0", n, o_addr_error); end
        end
        i_instr_addr = BASE;
    endtask

    task automatic test_oob();
        logic [31:0] w15;
        run_op(1'b1, BASE + 32'(4 * DEPTH), '0);
        total++; if (o_data_in !== 32'h0) begin bad++; $display("FAIL oob_read got=%h exp=0", o_data_in); end
        total++; if (o_addr_error !== exp_err) begin bad++; $display("FAIL oob_err got=%b exp=%b", o_addr_error, exp_err); end
        w15 = model[DEPTH - 1];
        run_op(1'b0, BASE - 32'd4, $urandom);
        i_instr_addr = BASE + 32'(4 * (DEPTH - 1)); #1;
        total++; if (o_instr_in !== w15) begin bad++; $display("FAIL oob_write_dropped got=%h exp=%h", o_instr_in, w15); end
        run_op(1'b1, BASE, '0);
        total++; if (o_addr_error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", o_addr_error); end
        total++; if (o_data_in !== exp_din) begin bad++; $display("FAIL after_oob_read got=%h exp=%h", o_data_in, exp_din); end
        i_instr_addr = BASE + 32'(4 * DEPTH); #1;
        total++; if (o_instr_in !== 32'h0) begin bad++; $display("FAIL oob_fetch got=%h exp=0", o_instr_in); end
        i_instr_addr = BASE;
    endtask

    task automatic test_reset_mid_load();
        int idxs [3];
        idxs[0] = 2; idxs[1] = 7; idxs[2] = 12;
        rst_n = 1'b0; #1;
        total++; if (o_core_reset !== 1'b1) begin bad++; $display("FAIL run_abort_core got=%b exp=1", o_core_reset); end
        clear_model();
        idle();
        tick();
        rst_n = 1'b1;
        repeat (DEPTH) tick();
        for (int k = 0; k < 3; k++) begin
            i_load_valid = 1'b1; i_load_addr = waddr(idxs[k]); i_load_data = $urandom | 32'h1;
            tick();
            $display("load addr=%h data=%h", i_load_addr, i_load_data);
        end
        i_load_addr = BASE + 32'(4 * DEPTH);
        tick();
        i_load_valid = 1'b0;
        total++; if (o_addr_error !== 1'b1) begin bad++; $display("FAIL load_oob_err got=%b exp=1", o_addr_error); end
        rst_n = 1'b0; #1;
        total++; if (o_core_reset !== 1'b1) begin bad++; $display("FAIL mid_load_core got=%b exp=1", o_core_reset); end
        total++; if (o_load_ready !== 1'b0) begin bad++; $display("FAIL mid_load_ready got=%b exp=0", o_load_ready); end
        total++; if (o_addr_error !== 1'b0) begin bad++; $display("FAIL mid_load_err got=%b exp=0", o_addr_error); end
        tick();
        rst_n = 1'b1;
        repeat (DEPTH) tick();
        total++; if (o_load_ready !== 1'b1) begin bad++; $display("FAIL reload_ready got=%b exp=1", o_load_ready); end
        for (int k = 0; k < 3; k++) begin
            i_instr_addr = waddr(idxs[k]); #1;
            total++; if (o_instr_in !== model[idxs[k]]) begin bad++; $display("FAIL reload_cleared[%0d] got=%h exp=%h", idxs[k], o_instr_in, model[idxs[k]]); end
        end
    endtask

    initial begin
        power_up();
        test_load();
        test_reset();
        test_load();
        test_back_to_back();
        test_random_rw();
        test_oob();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
